// File: rtl/sipo_iob_pkg.sv
// Shared types and helpers for the IOB serial-in/parallel-out deserializer.
// Optional parity support is enabled by defining SIPO_PARITY_EN.
package sipo_iob_pkg;

  typedef enum logic {SIPO_LSB_FIRST, SIPO_MSB_FIRST} sipo_order_t;

  // Counter width wide enough for WIDTH data bits plus an optional parity bit.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/sipo_deser_iob_if.sv
// Word-level bus of the IOB deserializer: bit strobe inputs, word handshake and status.
// PAR_ERR_IOB is present only when SIPO_PARITY_EN is defined.
interface sipo_deser_iob_if
  import sipo_iob_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = cnt_w(WIDTH);

  logic             EN_IOB;
  logic             DAT_IN_IOB;
  logic             CLR_IOB;
  logic             MSB_FIRST_IOB;
  logic             READY_IN_IOB;
  logic [WIDTH-1:0] WORD_OUT_IOB;
  logic             VALID_OUT_IOB;
  logic             OVF_OUT_IOB;
  logic [CntW-1:0]  CNT_OUT_IOB;
`ifdef SIPO_PARITY_EN
  logic             PAR_ERR_IOB;
`endif

  modport master (
`ifdef SIPO_PARITY_EN
    input  PAR_ERR_IOB,
`endif
    output EN_IOB, DAT_IN_IOB, CLR_IOB, MSB_FIRST_IOB, READY_IN_IOB,
    input  WORD_OUT_IOB, VALID_OUT_IOB, OVF_OUT_IOB, CNT_OUT_IOB
  );

  modport slave (
`ifdef SIPO_PARITY_EN
    output PAR_ERR_IOB,
`endif
    input  EN_IOB, DAT_IN_IOB, CLR_IOB, MSB_FIRST_IOB, READY_IN_IOB,
    output WORD_OUT_IOB, VALID_OUT_IOB, OVF_OUT_IOB, CNT_OUT_IOB
  );

endinterface

// File: rtl/sipo_iob_shreg.sv
// Shifter, bit counter, order latch and parity accumulator of the IOB deserializer.
// done_o pulses combinationally on the edge that accepts the last bit; word_o/par_o are valid then.
module sipo_iob_shreg
  import sipo_iob_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned NBits = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     dat_i,
  input  logic                     clr_i,
  input  logic                     msb_first_i,
  output logic [Width-1:0]         word_o,
  output logic                     done_o,
  output logic                     par_o,
  output logic [cnt_w(Width)-1:0]  cnt_o
);
  localparam int unsigned CntW = cnt_w(Width);

  logic [Width-1:0] data_q, data_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  sipo_order_t      order_q, order_d;
  logic             par_q, par_d;
  logic             accept, last;

  always_comb begin
    data_d  = data_q;
    cnt_d   = cnt_q;
    order_d = order_q;
    par_d   = par_q;
    accept  = en_i & ~clr_i;
    last    = accept && (cnt_q == CntW'(NBits - 1));
    if (clr_i) begin
      data_d  = '0;
      cnt_d   = '0;
      order_d = SIPO_LSB_FIRST;
      par_d   = 1'b0;
    end else if (accept) begin
      if (cnt_q == '0) order_d = sipo_order_t'(msb_first_i);
      // A trailing parity bit (cnt beyond the data bits) is never shifted in.
      if (cnt_q < CntW'(Width)) begin
        data_d = (order_d == SIPO_MSB_FIRST) ? {data_q[Width-2:0], dat_i}
                                             : {dat_i, data_q[Width-1:1]};
      end
      par_d = ((cnt_q == '0) ? 1'b0 : par_q) ^ dat_i;
      cnt_d = last ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      cnt_q   <= '0;
      order_q <= SIPO_LSB_FIRST;
      par_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      order_q <= order_d;
      par_q   <= par_d;
    end
  end

  assign word_o = data_d;
  assign done_o = last;
  assign par_o  = par_d;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/sipo_deser_iob.sv
// IOB deserializer top: assembles strobed bits into words behind a valid/ready holding register
// with a sticky overflow flag. Define SIPO_PARITY_EN for a trailing parity bit and PAR_ERR_IOB.
module sipo_deser_iob
  import sipo_iob_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic              CLOCK_IOB,
  input logic              RES_IOB,
  sipo_deser_iob_if.slave  bus
);
`ifdef SIPO_PARITY_EN
  localparam int unsigned NBits = WIDTH + 1;
`else
  localparam int unsigned NBits = WIDTH;
`endif

  logic [WIDTH-1:0] sr_word;
  logic             sr_done;
  logic             sr_par;

  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             load;
`ifdef SIPO_PARITY_EN
  logic             par_err_q, par_err_d;
`else
  logic             unused_par;
  logic             unused_parity_odd;
  assign unused_par        = sr_par;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  sipo_iob_shreg #(
    .Width (WIDTH),
    .NBits (NBits)
  ) u_shreg (
    .clk_i       (CLOCK_IOB),
    .rst_ni      (RES_IOB),
    .en_i        (bus.EN_IOB),
    .dat_i       (bus.DAT_IN_IOB),
    .clr_i       (bus.CLR_IOB),
    .msb_first_i (bus.MSB_FIRST_IOB),
    .word_o      (sr_word),
    .done_o      (sr_done),
    .par_o       (sr_par),
    .cnt_o       (bus.CNT_OUT_IOB)
  );

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
`ifdef SIPO_PARITY_EN
    par_err_d = par_err_q;
`endif
    // Load when the holding register is empty or is being drained on this very edge.
    load = sr_done && (!valid_q || bus.READY_IN_IOB);
    if (load) begin
      word_d  = sr_word;
      valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
      par_err_d = sr_par ^ (PARITY_ODD != 0);
`endif
    end else if (valid_q && bus.READY_IN_IOB) begin
      valid_d = 1'b0;
    end
    if (bus.CLR_IOB) begin
      ovf_d = 1'b0;
    end else if (sr_done && !load) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_IOB or negedge RES_IOB) begin
    if (!RES_IOB) begin
      word_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SIPO_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      word_q  <= word_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
`ifdef SIPO_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign bus.WORD_OUT_IOB  = word_q;
  assign bus.VALID_OUT_IOB = valid_q;
  assign bus.OVF_OUT_IOB   = ovf_q;
`ifdef SIPO_PARITY_EN
  assign bus.PAR_ERR_IOB   = par_err_q;
`endif

endmodule

// File: tb/tb_sipo_deser_iob.sv
// Scoreboard bench for sipo_deser_iob: directed cases plus random strobes against a word-level model.
// Builds with or without SIPO_PARITY_EN.
module tb_sipo_deser_iob;
  import sipo_iob_pkg::*;

  localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif
  localparam bit PODD = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sipo_deser_iob_if #(.WIDTH(W)) bus ();

  sipo_deser_iob #(
    .WIDTH      (W),
    .PARITY_ODD (0)
  ) dut (
    .CLOCK_IOB (clk),
    .RES_IOB   (rst_n),
    .bus       (bus)
  );

  int checks = 0;
  int passed = 0;

  // Word-level reference: bits collected per frame, order taken from the frame's first bit.
  bit           mbits[$];
  bit           morder;
  bit           occ;
  bit           ovf_m;
  logic [W-1:0] expw[$];
  bit           expp[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  task automatic model_edge(input bit en, input bit dat, input bit clr, input bit msb,
                            input bit rdy);
    bit           drained;
    bit           done;
    bit           p;
    logic [W-1:0] w;
    drained = occ && rdy;
    done    = 1'b0;
    w       = '0;
    p       = 1'b0;
    if (clr) begin
      mbits.delete();
      ovf_m = 1'b0;
    end else if (en) begin
      if (mbits.size() == 0) morder = msb;
      mbits.push_back(dat);
      if (mbits.size() == NB) begin
        for (int i = 0; i < W; i++) begin
          if (morder) w[W-1-i] = mbits[i];
          else        w[i]     = mbits[i];
        end
        foreach (mbits[i]) p ^= mbits[i];
        mbits.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (!occ || rdy) begin
        expw.push_back(w);
        expp.push_back(p ^ PODD);
        occ = 1'b1;
      end else begin
        ovf_m = 1'b1;
      end
    end else if (drained) begin
      occ = 1'b0;
    end
  endtask

  task automatic step(input bit en, input bit dat, input bit clr, input bit msb, input bit rdy);
    bus.EN_IOB        = en;
    bus.DAT_IN_IOB    = dat;
    bus.CLR_IOB       = clr;
    bus.MSB_FIRST_IOB = msb;
    bus.READY_IN_IOB  = rdy;
    model_edge(en, dat, clr, msb, rdy);
    @(posedge clk);
    #1;
    chk("cnt", int'(bus.CNT_OUT_IOB), mbits.size());
    chk("valid", int'(bus.VALID_OUT_IOB), int'(occ));
    chk("ovf", int'(bus.OVF_OUT_IOB), int'(ovf_m));
  endtask

  // seq[i] is the i-th bit on the wire; a parity bit (if any) is appended, optionally inverted.
  task automatic send_seq(input logic [W-1:0] seq, input bit msb0, input bit toggle,
                          input bit rdy_body, input bit rdy_last, input bit pflip);
    bit dat;
    for (int i = 0; i < NB; i++) begin
      if (i < W) dat = seq[i];
      else       dat = (^seq) ^ PODD ^ pflip;
      step(1'b1, dat, 1'b0, toggle ? (msb0 ^ i[0]) : msb0,
           (i == NB - 1) ? rdy_last : rdy_body);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.VALID_OUT_IOB && bus.READY_IN_IOB) begin
      if (expw.size() == 0) begin
        checks++;
        $display("FAIL word_unexpected: got %0h, expected no word", bus.WORD_OUT_IOB);
      end else begin
        chk("word", int'(bus.WORD_OUT_IOB), int'(expw.pop_front()));
`ifdef SIPO_PARITY_EN
        chk("par_err", int'(bus.PAR_ERR_IOB), int'(expp.pop_front()));
`else
        void'(expp.pop_front());
`endif
      end
    end
  end

  initial begin
    bus.EN_IOB        = 1'b0;
    bus.DAT_IN_IOB    = 1'b0;
    bus.CLR_IOB       = 1'b0;
    bus.MSB_FIRST_IOB = 1'b0;
    bus.READY_IN_IOB  = 1'b0;
    #1;
    chk("rst_word", int'(bus.WORD_OUT_IOB), 0);
    chk("rst_valid", int'(bus.VALID_OUT_IOB), 0);
    chk("rst_ovf", int'(bus.OVF_OUT_IOB), 0);
    chk("rst_cnt", int'(bus.CNT_OUT_IOB), 0);
    #6 rst_n = 1'b1;

    // LSB-first: 0,1,1,1,1,0,0,0 -> 8'h1E
    send_seq(8'h1E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t1_valid", int'(bus.VALID_OUT_IOB), 1);
    chk("t1_word", int'(bus.WORD_OUT_IOB), 'h1E);

    // MSB-first with the order input toggling mid-word -> 8'h78
    send_seq(8'h1E, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t2_word", int'(bus.WORD_OUT_IOB), 'h78);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure overflow
    send_seq(rev(8'h11), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_seq(rev(8'h22), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_word", int'(bus.WORD_OUT_IOB), 'h11);
    chk("t3_ovf", int'(bus.OVF_OUT_IOB), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_drain_valid", int'(bus.VALID_OUT_IOB), 0);
    chk("t3_drain_ovf", int'(bus.OVF_OUT_IOB), 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_clr_ovf", int'(bus.OVF_OUT_IOB), 0);

    // Drain and completion on the same edge
    send_seq(rev(8'h11), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_seq(rev(8'h22), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_word", int'(bus.WORD_OUT_IOB), 'h22);
    chk("t4_valid", int'(bus.VALID_OUT_IOB), 1);
    chk("t4_ovf", int'(bus.OVF_OUT_IOB), 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Abort with a pending word
    send_seq(rev(8'h5A), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_cnt", int'(bus.CNT_OUT_IOB), 0);
    chk("t5_valid", int'(bus.VALID_OUT_IOB), 1);
    chk("t5_word", int'(bus.WORD_OUT_IOB), 'h5A);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send_seq(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_ones", int'(bus.WORD_OUT_IOB), 'hFF);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-word with a pending word
    send_seq(rev(8'hA3), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_cnt", int'(bus.CNT_OUT_IOB), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_word", int'(bus.WORD_OUT_IOB), 0);
    chk("t6_valid", int'(bus.VALID_OUT_IOB), 0);
    chk("t6_ovf", int'(bus.OVF_OUT_IOB), 0);
    chk("t6_cnt0", int'(bus.CNT_OUT_IOB), 0);
    mbits.delete();
    expw.delete();
    expp.delete();
    occ   = 1'b0;
    ovf_m = 1'b0;
    #3 rst_n = 1'b1;

`ifdef SIPO_PARITY_EN
    send_seq(rev(8'hA5), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t6_par_err1", int'(bus.PAR_ERR_IOB), 1);
    send_seq(rev(8'hA5), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("t6_par_err0", int'(bus.PAR_ERR_IOB), 0);
`endif

    for (int n = 0; n < 2000; n++) begin
      step(($urandom % 4) != 0, 1'($urandom), ($urandom % 64) == 0, 1'($urandom),
           ($urandom % 3) != 0);
    end
    for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("queue_empty", expw.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
